// File: rtl/aes_sbox_array.sv
// Array of LANES share-masked AES S-box cores behind a valid-token pipeline and a credit-gated output FIFO.
// Shares are recombined only inside a lane core; everything outside moves whole share vectors.
module aes_sbox_array #(
  parameter int LANES      = 4,
  parameter int SHARES     = 2,
  parameter int LATENCY    = 5,
  parameter int RND_W      = 40,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              ClkxCI,
  input  logic                              RstxBI,
  input  logic                              InValidxSI,
  output logic                              InReadyxSO,
  input  logic [LANES*SHARES*8-1:0]         InDataxDI,
  input  logic [LANES*RND_W-1:0]            RndxDI,
  input  logic                              RndValidxSI,
  output logic                              RndReadyxSO,
  output logic                              OutValidxSO,
  input  logic                              OutReadyxSI,
  output logic [LANES*SHARES*8-1:0]         OutDataxDO,
  input  logic                              FlushxSI,
  output logic                              RndErrxSO,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   InFlightxDO
);

  localparam int DW  = LANES*SHARES*8;
  localparam int SW  = SHARES*8;
  localparam int IFW = $clog2(FIFO_DEPTH+1);
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as x^254 (x^127 by square-and-multiply, then one square), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = x;
    for (int i = 0; i < 6; i++) inv = gf_mul(gf_mul(inv, inv), x);
    inv = gf_mul(inv, inv);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [SW-1:0] lane_core_in(input logic [SW-1:0] sh, input logic [RND_W-1:0] rnd);
    logic [7:0]    x, m;
    logic [SW-1:0] o;
    x = '0;
    for (int s = 0; s < SHARES; s++) x = x ^ sh[s*8 +: 8];
    m = sbox(x);
    o = '0;
    for (int s = 1; s < SHARES; s++) begin
      o[s*8 +: 8] = rnd[(s-1)*8 +: 8];
      m = m ^ rnd[(s-1)*8 +: 8];
    end
    o[7:0] = m;
    return o;
  endfunction

  // Per-stage refresh: the same folded random byte lands on share 0 and the last share.
  function automatic logic [DW-1:0] refresh(input logic [DW-1:0] v, input logic [LANES*RND_W-1:0] rnd);
    logic [DW-1:0] o;
    logic [7:0]    f;
    o = v;
    for (int l = 0; l < LANES; l++) begin
      f = '0;
      for (int i = 0; i < RND_W; i++) f[i%8] = f[i%8] ^ rnd[l*RND_W + i];
      o[l*SW +: 8]                = o[l*SW +: 8] ^ f;
      o[(l*SHARES+SHARES-1)*8 +: 8] = o[(l*SHARES+SHARES-1)*8 +: 8] ^ f;
    end
    return o;
  endfunction

  logic [DW-1:0]      r_stage [LATENCY];
  logic [LATENCY-1:0] r_tok;
  logic [DW-1:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]      r_wr, r_rd;
  logic [IFW-1:0]     r_cnt, r_inflight;
  logic               r_err;
  logic [DW-1:0]      w_core_in;
  logic               w_issue, w_wr, w_rd, w_any_tok;

  always_comb begin
    w_core_in = '0;
    for (int l = 0; l < LANES; l++)
      w_core_in[l*SW +: SW] = lane_core_in(InDataxDI[l*SW +: SW], RndxDI[l*RND_W +: RND_W]);
  end

  assign InReadyxSO  = RstxBI & ~FlushxSI & (r_inflight < IFW'(FIFO_DEPTH));
  assign w_issue     = InValidxSI & InReadyxSO & RndValidxSI;
  assign w_any_tok   = |r_tok;
  assign w_wr        = r_tok[LATENCY-1];
  assign OutValidxSO = (r_cnt != '0);
  assign w_rd        = OutValidxSO & OutReadyxSI & ~FlushxSI;
  assign OutDataxDO  = OutValidxSO ? r_mem[r_rd] : '0;
  assign RndReadyxSO = w_issue | w_any_tok;
  assign RndErrxSO   = r_err;
  assign InFlightxDO = r_inflight;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_tok <= '0;
      for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
    end else if (FlushxSI) begin
      r_tok <= '0;
      for (int i = 0; i < LATENCY; i++) r_stage[i] <= '0;
    end else begin
      r_tok[0]   <= w_issue;
      r_stage[0] <= w_issue ? w_core_in : '0;
      for (int i = 1; i < LATENCY; i++) begin
        r_tok[i]   <= r_tok[i-1];
        r_stage[i] <= refresh(r_stage[i-1], RndxDI);
      end
    end
  end

  // Credits cover tokens plus buffered entries, so a write never meets a full FIFO.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_inflight <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (FlushxSI) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_inflight <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_rd) begin
        r_mem[r_rd] <= '0;
        r_rd        <= (r_rd == PW'(FIFO_DEPTH-1)) ? '0 : r_rd + PW'(1);
      end
      if (w_wr) begin
        r_mem[r_wr] <= r_stage[LATENCY-1];
        r_wr        <= (r_wr == PW'(FIFO_DEPTH-1)) ? '0 : r_wr + PW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + IFW'(1);
        2'b01:   r_cnt <= r_cnt - IFW'(1);
        default: r_cnt <= r_cnt;
      endcase
      case ({w_issue, w_rd})
        2'b10:   r_inflight <= r_inflight + IFW'(1);
        2'b01:   r_inflight <= r_inflight - IFW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI)                         r_err <= 1'b0;
    else if (w_any_tok && !RndValidxSI)  r_err <= 1'b1;
  end

endmodule

// File: tb/tb_aes_sbox_array.sv
// Bench for aes_sbox_array: randomized batches scored against a table-driven S-box model
// through an issue-side queue and an independent output monitor.
module tb_aes_sbox_array;

  localparam int LANES = 4, SHARES = 2, LATENCY = 5, RND_W = 40, FIFO_DEPTH = 8;
  localparam int DW  = LANES*SHARES*8;
  localparam int IFW = $clog2(FIFO_DEPTH+1);

  logic                   ClkxCI = 1'b0;
  logic                   RstxBI;
  logic                   InValidxSI, InReadyxSO;
  logic [DW-1:0]          InDataxDI;
  logic [LANES*RND_W-1:0] RndxDI;
  logic                   RndValidxSI, RndReadyxSO;
  logic                   OutValidxSO, OutReadyxSI;
  logic [DW-1:0]          OutDataxDO;
  logic                   FlushxSI, RndErrxSO;
  logic [IFW-1:0]         InFlightxDO;

  aes_sbox_array #(.LANES(LANES), .SHARES(SHARES), .LATENCY(LATENCY), .RND_W(RND_W),
                   .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .ClkxCI(ClkxCI), .RstxBI(RstxBI), .InValidxSI(InValidxSI), .InReadyxSO(InReadyxSO),
    .InDataxDI(InDataxDI), .RndxDI(RndxDI), .RndValidxSI(RndValidxSI), .RndReadyxSO(RndReadyxSO),
    .OutValidxSO(OutValidxSO), .OutReadyxSI(OutReadyxSI), .OutDataxDO(OutDataxDO),
    .FlushxSI(FlushxSI), .RndErrxSO(RndErrxSO), .InFlightxDO(InFlightxDO));

  always #5 ClkxCI = ~ClkxCI;

  int errors = 0;
  int checks = 0;
  int n_issue = 0;
  logic [7:0] ref_sbox [256];
  logic [LANES*8-1:0] exp_q [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Multiplicative-group walk: p steps through powers of 3, q through powers of 1/3.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int k = 0; k < 255; k++) begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      ref_sbox[p] = x ^ 8'h63;
    end
    ref_sbox[0] = 8'h63;
  endtask

  function automatic logic [LANES*8-1:0] unmask(input logic [DW-1:0] d);
    logic [LANES*8-1:0] v;
    logic [7:0] x;
    v = '0;
    for (int l = 0; l < LANES; l++) begin
      x = 8'h00;
      for (int s = 0; s < SHARES; s++) x = x ^ d[(l*SHARES+s)*8 +: 8];
      v[l*8 +: 8] = x;
    end
    return v;
  endfunction

  function automatic logic [LANES*8-1:0] model(input logic [DW-1:0] d);
    logic [LANES*8-1:0] u, e;
    u = unmask(d);
    for (int l = 0; l < LANES; l++) e[l*8 +: 8] = ref_sbox[u[l*8 +: 8]];
    return e;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t;
  endfunction

  // Issue side of the scoreboard.
  always @(negedge ClkxCI) begin
    if (!RstxBI || FlushxSI) exp_q.delete();
    else if (InValidxSI && InReadyxSO && RndValidxSI) begin
      exp_q.push_back(model(InDataxDI));
      n_issue++;
    end
  end

  // Output monitor.
  always @(negedge ClkxCI) begin
    logic [LANES*8-1:0] e;
    if (RstxBI && !FlushxSI) begin
      if (!OutValidxSO) chk("out_zero_idle", OutDataxDO, '0);
      else if (OutReadyxSI) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got %0h expected no batch at %0t", OutDataxDO, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", unmask(OutDataxDO), e);
        end
      end
    end
  end

  task automatic step();
    logic [255:0] t;
    @(posedge ClkxCI);
    #1;
    t = rand256();
    RndxDI = t[LANES*RND_W-1:0];
  endtask

  task automatic rand_data();
    logic [255:0] t;
    t = rand256();
    InDataxDI = t[DW-1:0];
  endtask

  task automatic drain(input string name);
    InValidxSI  = 1'b0;
    OutReadyxSI = 1'b1;
    for (int i = 0; i < 100 && InFlightxDO != 0; i++) step();
    step();
    chk({name, "_inflight"}, InFlightxDO, 0);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int lat, base;
    build_sbox();
    RstxBI = 1'b1; InValidxSI = 1'b1; InDataxDI = '0; RndxDI = '0; RndValidxSI = 1'b1;
    OutReadyxSI = 1'b1; FlushxSI = 1'b0;
    #1 RstxBI = 1'b0;
    #1;
    chk("rst_in_ready", InReadyxSO, 0);
    chk("rst_out_valid", OutValidxSO, 0);
    chk("rst_out_data", OutDataxDO, 0);
    chk("rst_rnd_ready", RndReadyxSO, 0);
    chk("rst_rnd_err", RndErrxSO, 0);
    chk("rst_inflight", InFlightxDO, 0);
    step(); step();
    chk("rst_hold_in_ready", InReadyxSO, 0);
    InValidxSI = 1'b0;
    RstxBI = 1'b1;
    step();

    // Lane 0 shares 0x5A/0x09 (S-box of 0x53 is 0xED); other lanes zero shares give 0x63.
    InDataxDI = '0;
    InDataxDI[7:0] = 8'h5A;
    InDataxDI[15:8] = 8'h09;
    InValidxSI = 1'b1;
    #1 chk("dir_in_ready", InReadyxSO, 1);
    step();
    InValidxSI = 1'b0;
    lat = 1;
    while (OutValidxSO !== 1'b1 && lat < 40) begin step(); lat++; end
    chk("min_latency", lat, LATENCY+1);
    chk("lane0_xor_ED", OutDataxDO[7:0] ^ OutDataxDO[15:8], 8'hED);
    chk("lane1_xor_63", OutDataxDO[23:16] ^ OutDataxDO[31:24], 8'h63);
    InDataxDI = '0;
    InValidxSI = 1'b1;
    step();
    drain("zero_batch");

    for (int i = 0; i < 80; i++) begin
      InValidxSI  = ($urandom_range(3) != 0);
      OutReadyxSI = ($urandom_range(3) != 0);
      rand_data();
      step();
    end
    drain("random");

    OutReadyxSI = 1'b0;
    base = n_issue;
    InValidxSI = 1'b1;
    for (int i = 0; i < 20; i++) begin rand_data(); step(); end
    chk("fill_accepted", n_issue - base, FIFO_DEPTH);
    chk("fill_in_ready", InReadyxSO, 0);
    chk("fill_inflight", InFlightxDO, FIFO_DEPTH);
    chk("fill_out_valid", OutValidxSO, 1);
    drain("fill");

    OutReadyxSI = 1'b0;
    InValidxSI = 1'b1;
    for (int i = 0; i < 2; i++) begin rand_data(); step(); end
    InValidxSI = 1'b0;
    for (int i = 0; i < LATENCY+2; i++) step();
    InValidxSI = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_data(); step(); end
    chk("pre_flush_inflight", InFlightxDO, 5);
    FlushxSI = 1'b1;
    OutReadyxSI = 1'b1;
    #1 chk("flush_in_ready", InReadyxSO, 0);
    step();
    FlushxSI = 1'b0;
    InValidxSI = 1'b0;
    chk("flush_out_valid", OutValidxSO, 0);
    chk("flush_out_data", OutDataxDO, 0);
    chk("flush_inflight", InFlightxDO, 0);
    for (int i = 0; i < LATENCY+2; i++) step();
    chk("flush_no_late_out", OutValidxSO, 0);
    rand_data();
    InValidxSI = 1'b1;
    step();
    drain("post_flush");

    base = n_issue;
    InValidxSI = 1'b1;
    for (int i = 0; i < 20; i++) begin rand_data(); step(); end
    chk("throughput_accepted", n_issue - base, 20);
    drain("throughput");

    chk("rnd_err_clean", RndErrxSO, 0);
    rand_data();
    InValidxSI = 1'b1;
    step();
    base = n_issue;
    RndValidxSI = 1'b0;
    rand_data();
    #1 chk("rnd_ready_in_flight", RndReadyxSO, 1);
    step();
    RndValidxSI = 1'b1;
    InValidxSI = 1'b0;
    chk("rnd_drop_no_issue", n_issue - base, 0);
    chk("rnd_err_set", RndErrxSO, 1);
    for (int i = 0; i < 10; i++) step();
    chk("rnd_err_sticky", RndErrxSO, 1);
    drain("rnd_err");

    InValidxSI = 1'b1;
    for (int i = 0; i < 8; i++) begin rand_data(); step(); end
    #2 RstxBI = 1'b0;
    #1;
    chk("async_in_ready", InReadyxSO, 0);
    chk("async_out_valid", OutValidxSO, 0);
    chk("async_out_data", OutDataxDO, 0);
    chk("async_rnd_ready", RndReadyxSO, 0);
    chk("async_rnd_err", RndErrxSO, 0);
    chk("async_inflight", InFlightxDO, 0);
    step(); step();
    base = n_issue;
    RstxBI = 1'b1;
    rand_data();
    #1 chk("release_in_ready", InReadyxSO, 1);
    step();
    chk("release_issue", n_issue - base, 1);
    drain("release");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/aes_sbox_array.md
AES_SBOX_ARRAY -- requirements
Module: aes_sbox_array

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel masked S-box lanes (1..16).
REQ-002 SHALL have parameter SHARES, default 2, Boolean shares per byte (2..4).
REQ-003 SHALL have parameter LATENCY, default 5, fixed core pipeline depth in cycles (>=1).
REQ-004 SHALL have parameter RND_W, default 40, random bits consumed per lane per cycle.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, output buffer entries (power of two, >= LATENCY).
REQ-006 ClkxCI  in  1  single clock; all state updates on its rising edge.
REQ-007 RstxBI  in  1  reset, asynchronous and active-low.
REQ-008 InValidxSI  in  1  input batch valid.
REQ-009 InReadyxSO  out  1  block accepts a batch this cycle.
REQ-010 InDataxDI  in  LANES*SHARES*8  lane l share s byte at bits [(l*SHARES+s)*8 +: 8].
REQ-011 RndxDI  in  LANES*RND_W  fresh randomness, lane l at [l*RND_W +: RND_W].
REQ-012 RndValidxSI  in  1  RndxDI holds fresh bits this cycle.
REQ-013 RndReadyxSO  out  1  randomness consumed this cycle.
REQ-014 OutValidxSO  out  1  output batch valid.
REQ-015 OutReadyxSI  in  1  consumer accepts output batch.
REQ-016 OutDataxDO  out  LANES*SHARES*8  masked S-box results, same packing as input.
REQ-017 FlushxSI  in  1  synchronous flush of all in-flight and buffered batches.
REQ-018 RndErrxSO  out  1  sticky randomness-starvation error.
REQ-019 InFlightxDO  out  clog2(FIFO_DEPTH+1)  in-flight plus buffered batch count.

Function
REQ-020 Each lane SHALL compute a SHARES-share masked AES S-box; XOR of output shares SHALL equal SBOX(XOR of input shares).
REQ-021 Lane cores SHALL be free-running pipelines of exactly LATENCY cycles, never stalled.
REQ-022 Issue SHALL occur when InValidxSI & InReadyxSO & RndValidxSI; a batch SHALL NOT issue without fresh randomness.
REQ-023 InReadyxSO SHALL be 1 iff InFlightxDO < FIFO_DEPTH and FlushxSI = 0.
REQ-024 A valid-token shift register of depth LATENCY SHALL track issued batches; token exit SHALL write the core outputs into the output FIFO.
REQ-025 InFlightxDO SHALL increment on issue, decrement on output handshake, and stay unchanged when both occur in the same cycle.
REQ-026 Credit gating SHALL guarantee the FIFO never overflows; a FIFO write while full is a design error.
REQ-027 RndReadyxSO SHALL be 1 in every cycle where an issue occurs or any token is in the pipeline.
REQ-028 RndErrxSO SHALL set when RndReadyxSO = 1 and RndValidxSI = 0 with a token in flight; it SHALL clear only on reset.
REQ-029 Minimum latency SHALL be LATENCY+1 cycles from issue to OutValidxSO with an empty FIFO; sustained throughput SHALL be one batch per cycle while OutReadyxSI = 1.
REQ-030 OutDataxDO SHALL be all-zero whenever OutValidxSO = 0; no stale share SHALL be driven.
REQ-031 The FIFO SHALL be first-in first-out; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 FlushxSI = 1 SHALL, in the next cycle, clear all tokens, empty the FIFO, zero the stored share registers and set InFlightxDO = 0; issue and output handshakes in the flush cycle SHALL be ignored.
REQ-033 Share separation SHALL hold: no combinational path SHALL XOR two shares of the same byte outside the lane cores.

Reset
REQ-034 While RstxBI = 0: InReadyxSO = 0, OutValidxSO = 0, OutDataxDO = 0, RndReadyxSO = 0, RndErrxSO = 0, InFlightxDO = 0, tokens and FIFO cleared.
REQ-035 Reset assertion mid-operation SHALL discard all batches; the first issue SHALL be possible in the first cycle after release.

Verification
REQ-036 LANES=1, SHARES=2: shares 0x5A,0x09 issued with random bits, OutReadyxSI=1 -> OutValidxSO after LATENCY+1 cycles, share XOR = 0xED.
REQ-037 All lanes input shares 0x00,0x00 -> every lane output share XOR = 0x63.
REQ-038 OutReadyxSI=0, continuous valid input -> exactly FIFO_DEPTH batches accepted, InReadyxSO=0, InFlightxDO=FIFO_DEPTH; release -> batches emitted in order, none lost.
REQ-039 RndValidxSI dropped for one cycle with tokens in flight -> RndErrxSO=1 next cycle and stays 1 until reset; no issue during the drop.
REQ-040 FlushxSI pulse with 3 tokens in flight and 2 buffered -> next cycle OutValidxSO=0, OutDataxDO=0, InFlightxDO=0; subsequent batch output correct.
REQ-041 RstxBI asserted asynchronously mid-burst -> all outputs at reset values immediately, with no clock edge required.
